// File: rtl/axi4_mem_arbiter_if.sv
// Bus bundle between the AXI4 channel engines, the arbiter and the memory.
// The slave modport is the arbiter side and the master modport is the engine/memory side.
interface axi4_mem_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic                  wr_req;
    logic [ADDR_W-1:0]     wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_last;
    logic                  wr_gnt;
    logic                  rd_req;
    logic [ADDR_W-1:0]     rd_addr;
    logic                  rd_last;
    logic                  rd_gnt;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_data_valid;
    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  wr_req, wr_addr, wr_data, wr_last,
        input  rd_req, rd_addr, rd_last, mem_rdata,
        output wr_gnt, rd_gnt, rd_data, rd_data_valid,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output wr_req, wr_addr, wr_data, wr_last,
        output rd_req, rd_addr, rd_last, mem_rdata,
        input  wr_gnt, rd_gnt, rd_data, rd_data_valid,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/axi4_mem_arbiter.sv
// Round-robin burst arbiter between the AXI4 write and read engines for one memory port.
// Optional ARB_BURST_LIMIT_EN caps each grant at MAX_BEATS beats.
module axi4_mem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int MAX_BEATS  = 16
) (
    input  logic               ACLK,
    input  logic               ARESETn,
    axi4_mem_arbiter_if.slave  bus
);
    localparam int ADDR_W = $clog2(DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WR   = 2'd1;
    localparam logic [1:0] S_RD   = 2'd2;

    localparam logic OWN_RD = 1'b0;
    localparam logic OWN_WR = 1'b1;

    if (MAX_BEATS < 1 || MAX_BEATS > 256) begin : g_bad_max_beats
        $error("MAX_BEATS must be within 1..256");
    end

    logic [1:0] state_q, state_d;
    logic       last_owner_q, last_owner_d;
    logic       rd_valid_q, rd_valid_d;
    logic       wr_acc, rd_acc;
    logic       wr_done, rd_done;

`ifdef ARB_BURST_LIMIT_EN
    localparam logic [7:0] LIMIT = 8'(MAX_BEATS - 1);

    logic [7:0] beat_cnt_q, beat_cnt_d;
    logic       limit_hit;
`endif

    // Beat acceptance, burst completion and next-owner selection
    always_comb begin
        wr_acc       = bus.wr_req && (state_q == S_WR);
        rd_acc       = bus.rd_req && (state_q == S_RD);
`ifdef ARB_BURST_LIMIT_EN
        limit_hit    = (beat_cnt_q == LIMIT);
        wr_done      = wr_acc && (bus.wr_last || limit_hit);
        rd_done      = rd_acc && (bus.rd_last || limit_hit);
        beat_cnt_d   = beat_cnt_q;
`else
        wr_done      = wr_acc && bus.wr_last;
        rd_done      = rd_acc && bus.rd_last;
`endif
        state_d      = state_q;
        last_owner_d = last_owner_q;
        rd_valid_d   = rd_acc;
        case (state_q)
            S_IDLE: begin
`ifdef ARB_BURST_LIMIT_EN
                beat_cnt_d = 8'd0;
`endif
                if (bus.wr_req && (!bus.rd_req || last_owner_q == OWN_RD)) begin
                    state_d = S_WR;
                end else if (bus.rd_req) begin
                    state_d = S_RD;
                end
            end
            S_WR, S_RD: begin
`ifdef ARB_BURST_LIMIT_EN
                if (wr_acc || rd_acc) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                end
`endif
                if (wr_done || rd_done) begin
                    state_d      = S_IDLE;
                    last_owner_d = wr_done ? OWN_WR : OWN_RD;
`ifdef ARB_BURST_LIMIT_EN
                    beat_cnt_d   = 8'd0;
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Arbiter state, fairness pointer and registered read-return valid
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q      <= S_IDLE;
            last_owner_q <= OWN_RD;
            rd_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            rd_valid_q   <= rd_valid_d;
        end
    end

`ifdef ARB_BURST_LIMIT_EN
    // Beats accepted within the current grant
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            beat_cnt_q <= 8'd0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
        end
    end
`endif

    assign bus.wr_gnt        = (state_q == S_WR);
    assign bus.rd_gnt        = (state_q == S_RD);
    assign bus.rd_data       = bus.mem_rdata;
    assign bus.rd_data_valid = rd_valid_q;
    assign bus.mem_en        = wr_acc || rd_acc;
    assign bus.mem_we        = wr_acc;
    assign bus.mem_addr      = wr_acc ? bus.wr_addr :
                               rd_acc ? bus.rd_addr : {ADDR_W{1'b0}};
    assign bus.mem_wdata     = wr_acc ? bus.wr_data : {DATA_WIDTH{1'b0}};
endmodule

// File: tb/tb_axi4_mem_arbiter.sv
// Directed bench for axi4_mem_arbiter with a burst-level ownership model
// and a memory stand-in; define ARB_BURST_LIMIT_EN to exercise the beat cap.
module tb_axi4_mem_arbiter;
`ifdef ARB_BURST_LIMIT_EN
    localparam int MB  = 4;
    localparam bit LIM = 1'b1;
`else
    localparam int MB  = 16;
    localparam bit LIM = 1'b0;
`endif

    logic ACLK = 1'b0;
    logic ARESETn;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    axi4_mem_arbiter_if #(.DATA_WIDTH(32), .DEPTH(1024)) bus ();

    axi4_mem_arbiter #(
        .DATA_WIDTH(32),
        .DEPTH(1024),
        .MAX_BEATS(MB)
    ) dut (
        .ACLK(ACLK),
        .ARESETn(ARESETn),
        .bus(bus)
    );

    always #5 ACLK = ~ACLK;

    always @(posedge ACLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    // Memory stand-in: one-cycle read latency
    logic [31:0] ram [0:1023];
    always @(posedge ACLK) begin
        if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            else bus.mem_rdata <= ram[bus.mem_addr];
        end
    end

    // Burst-level model: who owns the port, who had it last, beats so far
    int          own_q;      // 0 none, 1 write engine, 2 read engine
    bit          last_wr_q;  // previous burst belonged to the write engine
    int          beats_q;
    bit          rv_q;
    logic [31:0] exp_rd_q;
    logic [31:0] mdl_mem [0:1023];

    always @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            own_q     <= 0;
            last_wr_q <= 1'b0;
            beats_q   <= 0;
            rv_q      <= 1'b0;
        end else begin
            rv_q     <= (own_q == 2) && bus.rd_req;
            exp_rd_q <= mdl_mem[bus.rd_addr];
            if (own_q == 1 && bus.wr_req) mdl_mem[bus.wr_addr] <= bus.wr_data;
            if (own_q == 0) begin
                if (bus.wr_req && bus.rd_req) own_q <= last_wr_q ? 2 : 1;
                else if (bus.wr_req) own_q <= 1;
                else if (bus.rd_req) own_q <= 2;
            end else if (own_q == 1 ? bus.wr_req : bus.rd_req) begin
                if ((own_q == 1 ? bus.wr_last : bus.rd_last) || (LIM && beats_q + 1 == MB)) begin
                    own_q     <= 0;
                    last_wr_q <= (own_q == 1);
                    beats_q   <= 0;
                end else begin
                    beats_q <= beats_q + 1;
                end
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge ACLK) begin
        logic wa;
        logic ra;
        wa = (own_q == 1) && bus.wr_req;
        ra = (own_q == 2) && bus.rd_req;
        chk("wr_gnt", bus.wr_gnt, own_q == 1);
        chk("rd_gnt", bus.rd_gnt, own_q == 2);
        chk("mem_en", bus.mem_en, wa || ra);
        chk("mem_we", bus.mem_we, wa);
        chk("mem_addr", bus.mem_addr, wa ? bus.wr_addr : ra ? bus.rd_addr : 10'd0);
        chk("mem_wdata", bus.mem_wdata, wa ? bus.wr_data : 32'd0);
        chk("rd_valid", bus.rd_data_valid, rv_q);
        if (rv_q) chk("rd_data", bus.rd_data, exp_rd_q);
    end

    // Read-return collector
    logic [31:0] rq[$];
    int          rc[$];
    always @(negedge ACLK) begin
        if (bus.rd_data_valid) begin
            rq.push_back(bus.rd_data);
            rc.push_back(cyc);
        end
    end

    task automatic wr_burst(input logic [9:0] a, input int n, input logic [31:0] d0,
                            input int gap_at, output int fc, output int lc);
        int i = 0;
        int g = 0;
        bit acc;
        bit gapped = 1'b0;
        fc = -1;
        lc = -1;
        bus.wr_req = 1'b1;
        while (i < n && g < 100) begin
            if (i == gap_at && !gapped) begin
                bus.wr_req = 1'b0;
                gapped = 1'b1;
                repeat (3) tick();
                bus.wr_req = 1'b1;
            end
            bus.wr_addr = a + 10'(i);
            bus.wr_data = d0 + 32'(i);
            bus.wr_last = (i == n - 1);
            acc = bus.wr_gnt;
            if (acc) begin
                if (i == 0) fc = cyc;
                lc = cyc;
            end
            tick();
            if (acc) i++;
            g++;
        end
        bus.wr_req = 1'b0;
        bus.wr_last = 1'b0;
        if (i < n) chk("wr_timeout", i, n);
    endtask

    task automatic rd_burst(input logic [9:0] a, input int n, output int fc, output int lc);
        int i = 0;
        int g = 0;
        bit acc;
        fc = -1;
        lc = -1;
        bus.rd_req = 1'b1;
        while (i < n && g < 100) begin
            bus.rd_addr = a + 10'(i);
            bus.rd_last = (i == n - 1);
            acc = bus.rd_gnt;
            if (acc) begin
                if (i == 0) fc = cyc;
                lc = cyc;
            end
            tick();
            if (acc) i++;
            g++;
        end
        bus.rd_req = 1'b0;
        bus.rd_last = 1'b0;
        if (i < n) chk("rd_timeout", i, n);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int wf, wl, rf, rl;
        int g;
        ARESETn = 1'b0;
        bus.wr_req = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.wr_last = 1'b0;
        bus.rd_req = 1'b0;
        bus.rd_addr = '0;
        bus.rd_last = 1'b0;
        repeat (3) tick();
        chk("rst_wr_gnt", bus.wr_gnt, 0);
        chk("rst_rd_gnt", bus.rd_gnt, 0);
        chk("rst_mem_en", bus.mem_en, 0);
        chk("rst_rd_valid", bus.rd_data_valid, 0);
        ARESETn = 1'b1;
        tick();

        // 1: four-beat write
        k = cyc;
        wr_burst(10'h10, 4, 32'hA0, -1, wf, wl);
        chk("t1_first", wf, k + 1);
        chk("t1_last", wl, k + 4);
        chk("t1_idle", bus.wr_gnt, 0);

        // 2: read back, no bubbles
        rq.delete();
        rc.delete();
        k = cyc;
        rd_burst(10'h10, 4, rf, rl);
        repeat (2) tick();
        chk("t2_first", rf, k + 1);
        chk("t2_count", rq.size(), 4);
        if (rq.size() == 4) begin
            for (int i = 0; i < 4; i++) chk("t2_data", rq[i], 32'hA0 + 32'(i));
            chk("t2_gapless", rc[3] - rc[0], 3);
        end

        // 3: simultaneous requests, write wins both ties
        k = cyc;
        fork
            wr_burst(10'h20, 4, 32'hB0, -1, wf, wl);
            rd_burst(10'h10, 4, rf, rl);
        join
        chk("t3_wr_first", wf, k + 1);
        chk("t3_rd_first", rf, k + 6);
        k = cyc;
        fork
            wr_burst(10'h24, 4, 32'hB4, -1, wf, wl);
            rd_burst(10'h20, 4, rf, rl);
        join
        chk("t3b_wr_first", wf, k + 1);
        chk("t3b_rd_first", rf, k + 6);

        // 4: write owner pauses three cycles, read waits for wr_last
        k = cyc;
        fork
            wr_burst(10'h30, 4, 32'hC0, 2, wf, wl);
            rd_burst(10'h24, 4, rf, rl);
        join
        chk("t4_wr_first", wf, k + 1);
        chk("t4_wr_last", wl, k + 7);
        chk("t4_rd_first", rf, k + 9);

        // 6: long write with a read arriving one cycle later
        k = cyc;
        fork
            wr_burst(10'h40, 8, 32'hD0, -1, wf, wl);
            begin
                tick();
                rd_burst(10'h30, 4, rf, rl);
            end
        join
        chk("t6_wr_first", wf, k + 1);
`ifdef ARB_BURST_LIMIT_EN
        chk("t6_rd_first", rf, k + 6);
        chk("t6_wr_last", wl, k + 14);
`else
        chk("t6_rd_first", rf, k + 10);
        chk("t6_wr_last", wl, k + 8);
`endif
        tick();

        // 5: reset during the third beat of a read burst
        bus.rd_req = 1'b1;
        bus.rd_addr = 10'h10;
        bus.rd_last = 1'b0;
        g = 0;
        while (!bus.rd_gnt && g < 20) begin
            tick();
            g++;
        end
        chk("t5_gnt", bus.rd_gnt, 1);
        tick();
        bus.rd_addr = 10'h11;
        tick();
        bus.rd_addr = 10'h12;
        chk("t5_pre_valid", bus.rd_data_valid, 1);
        #1 ARESETn = 1'b0;
        #1;
        chk("t5_wr_gnt", bus.wr_gnt, 0);
        chk("t5_rd_gnt", bus.rd_gnt, 0);
        chk("t5_valid", bus.rd_data_valid, 0);
        chk("t5_mem_en", bus.mem_en, 0);
        chk("t5_mem_we", bus.mem_we, 0);
        chk("t5_mem_addr", bus.mem_addr, 0);
        bus.rd_req = 1'b0;
        #1 ARESETn = 1'b1;
        repeat (3) begin
            tick();
            chk("t5_post_valid", bus.rd_data_valid, 0);
            chk("t5_post_gnt", bus.rd_gnt, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
